// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register: 1-cycle latency, stall hold, bubble/flush insertion, valid-masked enables.
// Retire counter with sticky wrap flag; stall_wb holds the stage, stall_mem alone inserts a bubble.
module wb_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int CP0A_W   = 5,
  parameter int NOP_ADDR = 0,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_mem,
  input  logic               stall_wb,
  input  logic               flush,
  input  logic               cnt_clr,
  input  logic               mem_valid,
  input  logic [RADDR_W-1:0] mem_wd,
  input  logic               mem_wreg,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_hi,
  input  logic [DATA_W-1:0]  mem_lo,
  input  logic               mem_whilo,
  input  logic               mem_llbit_we,
  input  logic               mem_llbit_val,
  input  logic               mem_cp0_we,
  input  logic [CP0A_W-1:0]  mem_cp0_waddr,
  input  logic [DATA_W-1:0]  mem_cp0_wdata,
  output logic               wb_valid,
  output logic [RADDR_W-1:0] wb_wd,
  output logic               wb_wreg,
  output logic [DATA_W-1:0]  wb_wdata,
  output logic [DATA_W-1:0]  wb_hi,
  output logic [DATA_W-1:0]  wb_lo,
  output logic               wb_whilo,
  output logic               wb_llbit_we,
  output logic               wb_llbit_val,
  output logic               wb_cp0_we,
  output logic [CP0A_W-1:0]  wb_cp0_waddr,
  output logic [DATA_W-1:0]  wb_cp0_wdata,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic               retire_ovf
);

  logic               r_valid;
  logic [RADDR_W-1:0] r_wd;
  logic               r_wreg;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_hi;
  logic [DATA_W-1:0]  r_lo;
  logic               r_whilo;
  logic               r_llbit_we;
  logic               r_llbit_val;
  logic               r_cp0_we;
  logic [CP0A_W-1:0]  r_cp0_waddr;
  logic [DATA_W-1:0]  r_cp0_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;

  logic w_bubble;
  logic w_capture;
  logic w_retire;

  // stall_wb alone (without stall_mem) is illegal upstream, but still just holds.
  assign w_bubble  = rst || flush || (!stall_wb && stall_mem);
  assign w_capture = !rst && !flush && !stall_wb && !stall_mem;
  assign w_retire  = w_capture && mem_valid;

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      r_valid     <= 1'b0;
      r_wd        <= RADDR_W'(NOP_ADDR);
      r_wreg      <= 1'b0;
      r_wdata     <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_whilo     <= 1'b0;
      r_llbit_we  <= 1'b0;
      r_llbit_val <= 1'b0;
      r_cp0_we    <= 1'b0;
      r_cp0_waddr <= '0;
      r_cp0_wdata <= '0;
    end else if (w_capture) begin
      // Data still follows an invalid slot; only its write enables are killed.
      r_valid     <= mem_valid;
      r_wd        <= mem_wd;
      r_wreg      <= mem_wreg && mem_valid;
      r_wdata     <= mem_wdata;
      r_hi        <= mem_hi;
      r_lo        <= mem_lo;
      r_whilo     <= mem_whilo && mem_valid;
      r_llbit_we  <= mem_llbit_we && mem_valid;
      r_llbit_val <= mem_llbit_val;
      r_cp0_we    <= mem_cp0_we && mem_valid;
      r_cp0_waddr <= mem_cp0_waddr;
      r_cp0_wdata <= mem_cp0_wdata;
    end
  end

  // Clear beats a coincident retire, so that instruction goes uncounted.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_retire) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == {CNT_W{1'b1}}) r_ovf <= 1'b1;
    end
  end

  assign wb_valid     = r_valid;
  assign wb_wd        = r_wd;
  assign wb_wreg      = r_wreg;
  assign wb_wdata     = r_wdata;
  assign wb_hi        = r_hi;
  assign wb_lo        = r_lo;
  assign wb_whilo     = r_whilo;
  assign wb_llbit_we  = r_llbit_we;
  assign wb_llbit_val = r_llbit_val;
  assign wb_cp0_we    = r_cp0_we;
  assign wb_cp0_waddr = r_cp0_waddr;
  assign wb_cp0_wdata = r_cp0_wdata;
  assign retire_cnt   = r_cnt;
  assign retire_ovf   = r_ovf;

endmodule
